timer_multi_param: RTL and testbench
====================================

Name: timer_multi_param

Overview:
- Parametrised successor to the team's fixed 4-digit stopwatch/timer top.
- Single-clock design. Clock enables come from internal prescalers; no divided clocks.
- Supports N BCD digits, three counting modes (stopwatch up, one-shot countdown, auto-reload countdown) plus clear, a done/alarm output, and a built-in multiplexed 7-segment scanner.
- Sits directly under the board top. It drives the anodes and segments itself.

Parameters:
- DIGITS, 4, number of BCD digits and anodes (2..8).
- TICK_DIV, 1000000, clk cycles per count tick.
- SCAN_DIV, 2000, clk cycles per display digit step.
- VALUE_W, 8, preset width in bits. Must be a multiple of 4 and no more than 4*DIGITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- stopstart  in  1  single-cycle pulse, already debounced and synchronised upstream.
- modesel  in  2  00 = up, 01 = countdown, 10 = countdown with auto-reload, 11 = clear.
- value  in  VALUE_W  BCD preset, loaded into the top VALUE_W/4 digits; lower digits load as 0.
- count  out  4*DIGITS  current BCD count (debug/readback).
- running  out  1  high in RUN.
- done  out  1  high while in DONE; in mode 10, a one-cycle pulse per reload.
- an  out  DIGITS  active-low digit enables, one-hot-low.
- sseg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE, count = 0, prescalers = 0, scan index = 0.
  - running = 0, done = 0.
  - an = all 1s, sseg = 8'hFF.
- Mode latch: mode is latched on the IDLE->RUN transition. Later changes among 00/01/10 are ignored until the block returns to IDLE. modesel = 11 forces IDLE from any state on the next edge (clear).
- Tick: the prescaler counts 0..TICK_DIV-1 only in RUN. tick = 1 on the cycle it wraps. The prescaler holds its value in PAUSE and clears on entering IDLE. The first tick occurs TICK_DIV cycles after the start edge.
- State IDLE:
  - Every cycle, count is set to 0 (modesel 00 or 11) or to the preset (01/10).
  - On stopstart:
    - modesel 00 -> RUN.
    - modesel 01: preset nonzero -> RUN; preset zero -> DONE.
    - modesel 10: preset nonzero -> RUN; preset zero -> ignored.
    - modesel 11 -> ignored.
- State RUN, on each tick:
  - Mode 00: BCD increment. All-9s wraps to 0 and stays in RUN.
  - Mode 01: BCD decrement. Reaching 0 -> DONE.
  - Mode 10: BCD decrement. Reaching 0 -> count reloads the preset (current value input), done pulses for 1 cycle, and the block stays in RUN.
  - stopstart -> PAUSE.
- State PAUSE: count and prescaler hold. stopstart -> RUN.
- State DONE: count = 0, done = 1. stopstart -> IDLE.
- Simultaneous events:
  - tick + stopstart in RUN: the tick update is applied and the block enters PAUSE.
  - If that tick reaches 0 in mode 01, DONE takes priority over PAUSE.
  - modesel 11 overrides every other event.
- BCD arithmetic: each digit is 0..9. Carry/borrow ripples combinationally within one cycle. Count changes only on the tick cycle, with 1-cycle latency from the tick to count.
- Display scanner:
  - A free-running SCAN_DIV prescaler advances the scan index 0..DIGITS-1, wrapping to 0. Index 0 is the least significant digit.
  - an and sseg are registered together, so an[i] = 0 exactly when index = i.
  - sseg[6:0] decodes the selected digit of count.
  - dp (sseg[7]) = 0 on index 2 only (seconds/hundredths separator). In DONE, dp = 0 on all digits.
  - After reset, an and sseg stay all 1s until the first scan step.

Test Plan (DIGITS=4, TICK_DIV=4, SCAN_DIV=2, VALUE_W=8):
- Async reset asserted mid-RUN, between clock edges -> immediately count = 16'h0000, an = 4'hF, sseg = 8'hFF, running = 0, done = 0.
- modesel = 00, stopstart pulse, run 12 cycles -> count = 16'h0003. Force count = 16'h9999 -> next tick gives 16'h0000, running stays 1.
- modesel = 01, value = 8'h01 -> IDLE count = 16'h0100. Start -> count = 16'h0000 at start + 400 cycles, done = 1, running = 0. Then stopstart -> IDLE, done = 0.
- modesel = 10, value = 8'h01, start -> after 100 ticks, done high for exactly 1 cycle, count = 16'h0100, running = 1. With value = 8'h00, stopstart is ignored.
- Mode 00: start, 2 ticks, stopstart -> hold 20 cycles with count = 16'h0002. Resume -> next tick after the remaining prescaler cycles. modesel = 11 during PAUSE -> IDLE, count = 0.
- count = 16'h0003, wait for scanning -> an cycles 1110, 1101, 1011, 0111, 2 cycles each. sseg = 8'hB0 on digit 0. dp = 0 only while an = 1011.

Source files
------------

// File: rtl/timer_multi_param.sv
// timer_multi_param: N-digit BCD stopwatch / countdown / auto-reload timer with a built-in 7-segment scanner.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   stopstart single-cycle start/stop pulse (debounced, synchronised)
//   modesel   00 up, 01 countdown, 10 auto-reload countdown, 11 clear
//   value     BCD preset loaded into the top VALUE_W/4 digits
//   count     current BCD count
//   running   high in RUN
//   done      high in DONE; one-cycle pulse per reload in mode 10
//   an        active-low one-hot digit enables
//   sseg      active-low segments {dp,g,f,e,d,c,b,a}
module timer_multi_param #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000000,
    parameter int SCAN_DIV = 2000,
    parameter int VALUE_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stopstart,
    input  logic [1:0]          modesel,
    input  logic [VALUE_W-1:0]  value,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                done,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          sseg
);
    localparam int CW = 4 * DIGITS;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     cnt_q, cnt_d, inc, dec, preset;
    logic [PW-1:0]     pre_q, pre_d;
    logic [SW-1:0]     spre_q, spre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        sseg_q, sseg_d;
    logic              tick, reload, running_q, done_q, scan_on_q, step, carry, borrow;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction
    // Preset occupies the most significant digits; lower digits are zero.
    assign preset = CW'(value) << (CW - VALUE_W);
    assign tick   = state_q == RUN && pre_q == PW'(TICK_DIV - 1);
    assign step   = spre_q == SW'(SCAN_DIV - 1);
    // Ripple BCD increment and decrement across all digits in one cycle.
    always_comb begin
        carry  = 1'b1;
        borrow = 1'b1;
        inc    = cnt_q;
        dec    = cnt_q;
        for (int i = 0; i < DIGITS; i++) begin
            inc[4*i +: 4] = carry ? (cnt_q[4*i +: 4] == 4'd9 ? 4'd0 : cnt_q[4*i +: 4] + 4'd1) : cnt_q[4*i +: 4];
            dec[4*i +: 4] = borrow ? (cnt_q[4*i +: 4] == 4'd0 ? 4'd9 : cnt_q[4*i +: 4] - 4'd1) : cnt_q[4*i +: 4];
            carry  = carry && cnt_q[4*i +: 4] == 4'd9;
            borrow = borrow && cnt_q[4*i +: 4] == 4'd0;
        end
    end
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        reload  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = modesel[0] ^ modesel[1] ? preset : '0;
                if (stopstart && modesel != 2'b11) begin
                    mode_d  = modesel;
                    state_d = (modesel == 2'b00 || value != '0) ? RUN : (modesel == 2'b01 ? DONE : IDLE);
                end
            end
            RUN: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (stopstart) state_d = PAUSE;
                if (tick) begin
                    cnt_d = mode_q == 2'b00 ? inc : (dec == '0 && mode_q == 2'b10) ? preset : dec;
                    // Reaching zero: one-shot ends in DONE (beats PAUSE), auto-reload pulses done.
                    if (mode_q != 2'b00 && dec == '0) begin
                        state_d = mode_q == 2'b01 ? DONE : state_d;
                        reload  = mode_q == 2'b10;
                    end
                end
            end
            PAUSE: if (stopstart) state_d = RUN;
            default: begin
                cnt_d = '0;
                if (stopstart) state_d = IDLE;
            end
        endcase
        if (modesel == 2'b11) begin
            state_d = IDLE;
            cnt_d   = '0;
            pre_d   = '0;
            reload  = 1'b0;
        end
    end
    // Display outputs are computed from next-state values so an/sseg line up with the registered index and count.
    always_comb begin
        spre_d = step ? '0 : spre_q + 1'b1;
        idx_d  = step && scan_on_q ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        an_d   = scan_on_q || step ? ~(DIGITS'(1) << idx_d) : '1;
        sseg_d = scan_on_q || step ? {!(32'(idx_d) == 2 || state_d == DONE), seg7(cnt_d[4*idx_d +: 4])} : 8'hFF;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= 2'b00;
            cnt_q     <= '0;
            pre_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            spre_q    <= '0;
            idx_q     <= '0;
            scan_on_q <= 1'b0;
            an_q      <= '1;
            sseg_q    <= 8'hFF;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            running_q <= state_d == RUN;
            done_q    <= state_d == DONE || reload;
            spre_q    <= spre_d;
            idx_q     <= idx_d;
            scan_on_q <= scan_on_q || step;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end
    assign count   = cnt_q;
    assign running = running_q;
    assign done    = done_q;
    assign an      = an_q;
    assign sseg    = sseg_q;
endmodule

// File: tb/tb_timer_multi_param.sv
// tb_timer_multi_param: scoreboard bench for timer_multi_param with DIGITS=4, TICK_DIV=4, SCAN_DIV=2, VALUE_W=8.
module tb_timer_multi_param;
    logic        clk = 1'b0, reset = 1'b0, stopstart = 1'b0;
    logic [1:0]  modesel = 2'b00;
    logic [7:0]  value = 8'h00;
    logic [15:0] count;
    logic        running, done;
    logic [3:0]  an, a_exp;
    logic [7:0]  sseg;
    logic [7:0]  seg_exp [4] = '{8'hB0, 8'hC0, 8'h40, 8'hC0};
    int          checks = 0, errors = 0, n = 0;
    string       tag_q [$];
    logic [31:0] exp_q [$];
    timer_multi_param #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .VALUE_W(8)) dut (
        .clk(clk), .reset(reset), .stopstart(stopstart), .modesel(modesel), .value(value),
        .count(count), .running(running), .done(done), .an(an), .sseg(sseg)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask
    task automatic pop_chk(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got %0h with nothing expected", got);
        end else check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask
    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask
    task automatic pulse();
        stopstart = 1'b1;
        cyc(1);
        stopstart = 1'b0;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        cyc(2);
        reset = 1'b1;
        cyc(1);
        // up-count: 3 ticks within 12 cycles of the start edge
        push("up_cnt3", 16'h0003); push("up_run", 1);
        pulse(); cyc(12);
        pop_chk(count); pop_chk(running);
        // pause with count 3, then watch the scanner
        pulse();
        for (int i = 0; i < 8; i++) begin
            a_exp = ~(4'b0001 << (i / 2));
            push($sformatf("scan_an%0d", i), a_exp);
            push($sformatf("scan_sseg%0d", i), seg_exp[i / 2]);
        end
        while (an != 4'b0111 && n < 20) begin cyc(1); n++; end
        while (an != 4'b1110 && n < 40) begin cyc(1); n++; end
        check("scan_sync", an, 4'b1110);
        for (int i = 0; i < 8; i++) begin
            pop_chk(an); pop_chk(sseg);
            cyc(1);
        end
        // clear during PAUSE
        push("clr_cnt", 0); push("clr_run", 0);
        modesel = 2'b11; cyc(1); modesel = 2'b00;
        pop_chk(count); pop_chk(running);
        // pause holds count and prescaler, resume finishes remaining prescaler cycles
        push("pz_cnt", 16'h0002); push("pz_run", 0); push("rs_cnt2", 16'h0002); push("rs_cnt3", 16'h0003);
        cyc(1);
        pulse(); cyc(8); pulse(); cyc(20);
        pop_chk(count); pop_chk(running);
        pulse(); cyc(2); pop_chk(count);
        cyc(1); pop_chk(count);
        modesel = 2'b11; cyc(1); modesel = 2'b00;
        // asynchronous reset between clock edges while running
        push("ar_count", 0); push("ar_an", 4'hF); push("ar_sseg", 8'hFF); push("ar_run", 0); push("ar_done", 0);
        pulse(); cyc(6);
        #2 reset = 1'b0;
        #1;
        pop_chk(count); pop_chk(an); pop_chk(sseg); pop_chk(running); pop_chk(done);
        cyc(1); reset = 1'b1; cyc(1);
        // one-shot countdown from 0100
        modesel = 2'b01; value = 8'h01;
        push("dn_idle", 16'h0100); push("dn_1", 16'h0001); push("dn_zero", 0);
        push("dn_done", 1); push("dn_run", 0); push("dn_dp", 0); push("dn_back", 0);
        cyc(2); pop_chk(count);
        pulse(); cyc(399); pop_chk(count);
        cyc(1); pop_chk(count); pop_chk(done); pop_chk(running); pop_chk(sseg[7]);
        pulse(); pop_chk(done);
        // stopstart on the final tick: DONE wins over PAUSE
        push("pri_done", 1); push("pri_cnt", 0);
        cyc(1); pulse(); cyc(399); pulse();
        pop_chk(done); pop_chk(count);
        pulse();
        // zero preset in one-shot goes straight to DONE
        value = 8'h00;
        push("z_done", 1); push("z_run", 0);
        cyc(1); pulse(); pop_chk(done); pop_chk(running);
        pulse(); value = 8'h01;
        // auto-reload countdown
        modesel = 2'b10;
        push("rl_cnt1", 16'h0001); push("rl_nodone", 0); push("rl_done", 1);
        push("rl_cnt", 16'h0100); push("rl_run", 1); push("rl_pulse", 0);
        cyc(1); pulse(); cyc(399); pop_chk(count); pop_chk(done);
        cyc(1); pop_chk(done); pop_chk(count); pop_chk(running);
        cyc(1); pop_chk(done);
        modesel = 2'b11; cyc(1); modesel = 2'b10; value = 8'h00;
        push("rlz_run", 0); push("rlz_cnt", 0);
        cyc(1); pulse(); cyc(3); pop_chk(running); pop_chk(count);
        // up-count all-9s wraps to zero and keeps running
        modesel = 2'b11; cyc(1); modesel = 2'b00;
        push("wr_9999", 16'h9999); push("wr_0", 0); push("wr_run", 1);
        cyc(1); pulse(); cyc(39996); pop_chk(count);
        cyc(4); pop_chk(count); pop_chk(running);
        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
